seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DIGITS, 4, number of multiplexed digits (2..16).
REQ-002 Parameter SEG_W, 8, segment bus width (segments a..g plus dp).
REQ-003 Parameter PRESCALE, 1024, clocks each digit is lit per scan slot (>=1).
REQ-004 Parameter BLANK_CYCLES, 16, all-off clocks between slots (>=0).
REQ-005 Clk  in  1  single clock; all state changes on rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 wr_en  in  1  write strobe for digit register.
REQ-008 wr_addr  in  $clog2(DIGITS)  digit index to write.
REQ-009 wr_data  in  SEG_W  digit value.
REQ-010 enable  in  1  level: 1 = scanning, 0 = display dark.
REQ-011 seg_out  out  SEG_W  registered, active-high segment drive.
REQ-012 dig_sel  out  DIGITS  registered, one-hot or zero, active-high digit select.
REQ-013 cur_digit  out  $clog2(DIGITS)  index of current slot.
REQ-014 frame_done  out  1  one-cycle pulse when the last digit's slot ends.

Function
REQ-015 SHALL hold DIGITS registers of SEG_W bits; wr_en with wr_addr<DIGITS updates digit_reg[wr_addr] at that edge.
REQ-016 SHALL ignore writes with wr_addr>=DIGITS, with no side effects.
REQ-017 FSM states SHALL be IDLE, BLANK, SHOW; phase counter counts clocks within the current state.
REQ-018 IDLE: dig_sel=0, seg_out=0, cur_digit=0; enable=1 -> BLANK (or SHOW if BLANK_CYCLES=0) next cycle.
REQ-019 BLANK SHALL last exactly BLANK_CYCLES clocks with dig_sel=0, seg_out=0, then -> SHOW.
REQ-020 SHOW SHALL last exactly PRESCALE clocks; dig_sel one-hot at cur_digit; seg_out reloaded every cycle from digit_reg[cur_digit].
REQ-021 Write-to-output latency SHALL be 2 cycles during SHOW of the written digit (register, then output register).
REQ-022 SHOW end: cur_digit increments, wrapping DIGITS-1 -> 0; frame_done pulses on the wrap cycle; -> BLANK.
REQ-023 enable=0 in any state SHALL force IDLE next cycle; re-enable restarts at digit 0.
REQ-024 Write coinciding with enable fall or with the slot transition SHALL still be committed.
REQ-025 dig_sel SHALL never have more than one bit set.

Reset
REQ-026 Reset SHALL clear all digit registers, phase counter, cur_digit, seg_out, dig_sel, frame_done, and enter IDLE; Reset dominates wr_en and enable.

Configuration
REQ-027 Macro SEG_SCAN_HEXDEC_EN defined: seg_out[6:0] = hex-to-7-segment of digit_reg[cur_digit][3:0] (bit0=a .. bit6=g), seg_out[7] = digit_reg[cur_digit][7] (dp); SEG_W SHALL be 8.
REQ-028 Macro undefined: seg_out = digit_reg[cur_digit] raw passthrough; any SEG_W legal.

Structure
REQ-029 Package seg_scan_pkg SHALL hold the state enum and the 16-entry hex-to-segment constant table.
REQ-030 Sub-module seg_hex7 (combinational nibble decoder) SHALL be instantiated only under SEG_SCAN_HEXDEC_EN.

Verification (DIGITS=4, PRESCALE=4, BLANK_CYCLES=1)
REQ-031 Reset asserted 3 cycles with enable=1 -> seg_out=0x00, dig_sel=0000, frame_done=0 throughout; IDLE after release until next edge.
REQ-032 Write 0x3F to addr 2, enable=1 -> per slot 1 cycle dig_sel=0000 then 4 cycles one-hot; digit 2 shows 0x3F, others 0x00; frame_done every 20 cycles.
REQ-033 Write 0x55 to addr 5 -> all four digit registers unchanged, scan timing unchanged.
REQ-034 enable=0 on 2nd SHOW cycle of digit 1 -> next cycle dig_sel=0000, seg_out=0x00; enable=1 -> BLANK then digit 0.
REQ-035 Write 0x06 to digit 0 on its 1st SHOW cycle -> seg_out=0x06 two cycles later, still within slot.
REQ-036 HEXDEC_EN: write 0x8A -> seg_out=0xF7; write 0x00 -> seg_out=0x3F.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  // Hex nibble to segments, bit0 = a .. bit6 = g, active high.
  localparam logic [6:0] HEX7_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_hex7.sv
// Combinational hex nibble to seven-segment decoder.
module seg_hex7
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX7_LUT[nibble];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed display scan controller: digit register file, blank/show slot
// sequencing and registered drive. Define SEG_SCAN_HEXDEC_EN for hex decoding.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SEG_W        = 8,
  parameter int PRESCALE     = 1024,
  parameter int BLANK_CYCLES = 16
)
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [$clog2(DIGITS)-1:0] wr_addr,
  input  logic [SEG_W-1:0]          wr_data,
  input  logic                      enable,
  output logic [SEG_W-1:0]          seg_out,
  output logic [DIGITS-1:0]         dig_sel,
  output logic [$clog2(DIGITS)-1:0] cur_digit,
  output logic                      frame_done
);

  localparam int AW     = $clog2(DIGITS);
  localparam int PH_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PH_W-1:0] SHOW_LAST  = PH_W'(PRESCALE - 1);
  localparam logic [PH_W-1:0] BLANK_LAST = PH_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [AW-1:0]   LAST_DIG   = AW'(DIGITS - 1);
  localparam scan_state_t     SLOT_ENTRY = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

  scan_state_t       state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [AW-1:0]     cur_digit_q, cur_digit_d;
  logic              frame_done_q, frame_done_d;
  logic [SEG_W-1:0]  seg_out_q, seg_out_d;
  logic [DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic [SEG_W-1:0]  digit_q [DIGITS];
  logic [SEG_W-1:0]  digit_d [DIGITS];

  logic              wr_hit;
  logic [SEG_W-1:0]  cur_raw;
  logic [SEG_W-1:0]  shown;

  // Digit register file; out-of-range addresses are dropped entirely.
  always_comb begin
    wr_hit = wr_en && ({1'b0, wr_addr} < (AW + 1)'(DIGITS));
    for (int unsigned i = 0; i < DIGITS; i++) begin
      digit_d[i] = digit_q[i];
      if (wr_hit && (wr_addr == AW'(i))) begin
        digit_d[i] = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      cur_digit_q  <= '0;
      frame_done_q <= 1'b0;
      seg_out_q    <= '0;
      dig_sel_q    <= '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        digit_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cur_digit_q  <= cur_digit_d;
      frame_done_q <= frame_done_d;
      seg_out_q    <= seg_out_d;
      dig_sel_q    <= dig_sel_d;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        digit_q[i] <= digit_d[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cur_digit_d  = cur_digit_q;
    frame_done_d = 1'b0;
    if (!enable) begin
      state_d     = ST_IDLE;
      phase_d     = '0;
      cur_digit_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = SLOT_ENTRY;
          phase_d     = '0;
          cur_digit_d = '0;
        end
        ST_BLANK: begin
          if (phase_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        ST_SHOW: begin
          if (phase_q == SHOW_LAST) begin
            state_d = SLOT_ENTRY;
            phase_d = '0;
            if (cur_digit_q == LAST_DIG) begin
              cur_digit_d  = '0;
              frame_done_d = 1'b1;
            end else begin
              cur_digit_d = cur_digit_q + 1'b1;
            end
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          phase_d = '0;
        end
      endcase
    end
  end

  // Drive is computed from the next state so outputs line up with the state
  // register; reading digit_q (not digit_d) gives the two-cycle write latency.
  always_comb begin
    cur_raw = digit_q[cur_digit_d];
  end

`ifdef SEG_SCAN_HEXDEC_EN
  logic [6:0] hex_seg;

  seg_hex7 u_hex7 (
    .nibble (cur_raw[3:0]),
    .seg    (hex_seg)
  );

  always_comb begin
    shown = SEG_W'({cur_raw[7], hex_seg});
  end
`else
  always_comb begin
    shown = cur_raw;
  end
`endif

  always_comb begin
    dig_sel_d = '0;
    seg_out_d = '0;
    if (state_d == ST_SHOW) begin
      dig_sel_d[cur_digit_d] = 1'b1;
      seg_out_d              = shown;
    end
  end

  assign seg_out    = seg_out_q;
  assign dig_sel    = dig_sel_q;
  assign cur_digit  = cur_digit_q;
  assign frame_done = frame_done_q;

endmodule
